// File: rtl/data_writeback_cache_controller.sv
// Write-back, write-allocate data cache controller for a single-issue CPU.
// A hit completes in the same cycle. A miss stalls the CPU while the victim
// line is written back (only if it is valid and dirty) and the requested
// 4-word line is then fetched word by word over a simple handshaked bus.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   MemReadM/MemWriteM CPU load/store request
//   A                  CPU byte address (tag | index | word | byte)
//   RV, Dirty, RTag    valid, dirty and tag of the line selected by A
//   BusReady           memory finished the current word transfer
//   Stall              holds the CPU memory stage
//   CWE, DirtyIn       cache word write enable and dirty bit written with it
//   UseWD              cache write-data select: 1 = CPU data, 0 = bus data
//   CacheA             address presented to the cache arrays
//   WordSel            word of the cache line driven to the bus on writeback
//   BusRE, BusWE       bus word read / write strobes
//   BusA               word-aligned bus address
module data_writeback_cache_controller #(
  parameter int unsigned tagbits = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemReadM,
  input  logic               MemWriteM,
  input  logic [31:0]        A,
  input  logic               RV,
  input  logic               Dirty,
  input  logic [tagbits-1:0] RTag,
  input  logic               BusReady,
  output logic               Stall,
  output logic               CWE,
  output logic               DirtyIn,
  output logic               UseWD,
  output logic [31:0]        CacheA,
  output logic [1:0]         WordSel,
  output logic               BusRE,
  output logic               BusWE,
  output logic [31:0]        BusA
);

  typedef enum logic [1:0] {
    StReady     = 2'd0,
    StWriteback = 2'd1,
    StFetch     = 2'd2
  } state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_next;

  logic w_req;
  logic w_hit;

  assign w_req = MemReadM | MemWriteM;
  assign w_hit = RV & (RTag == A[31:32-tagbits]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StReady;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    Stall        = 1'b0;
    CWE          = 1'b0;
    DirtyIn      = 1'b0;
    UseWD        = 1'b0;
    CacheA       = A;
    WordSel      = 2'd0;
    BusRE        = 1'b0;
    BusWE        = 1'b0;
    BusA         = 32'd0;

    unique case (r_state)
      StReady: begin
        if (w_req) begin
          if (w_hit) begin
            if (MemWriteM) begin
              CWE     = 1'b1;
              UseWD   = 1'b1;
              DirtyIn = 1'b1;
            end
          end else begin
            Stall        = 1'b1;
            w_cnt_next   = 2'd0;
            w_state_next = (RV & Dirty) ? StWriteback : StFetch;
          end
        end
      end

      StWriteback: begin
        // Victim address is rebuilt from the stored tag and the current index.
        Stall   = 1'b1;
        BusWE   = 1'b1;
        WordSel = r_cnt;
        BusA    = {RTag, A[31-tagbits:4], r_cnt, 2'b00};
        if (BusReady) begin
          // 3 -> 0 wrap only happens together with the state change.
          w_cnt_next = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_next = StFetch;
          end
        end
      end

      StFetch: begin
        Stall  = 1'b1;
        BusRE  = 1'b1;
        BusA   = {A[31:4], r_cnt, 2'b00};
        CacheA = {A[31:4], r_cnt, 2'b00};
        if (BusReady) begin
          CWE        = 1'b1;
          w_cnt_next = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_next = StReady;
          end
        end
      end

      default: begin
        w_state_next = StReady;
        w_cnt_next   = 2'd0;
      end
    endcase

    // Keep the CPU and bus quiet while reset is held, even on a live request.
    if (!reset) begin
      Stall   = 1'b0;
      CWE     = 1'b0;
      DirtyIn = 1'b0;
      UseWD   = 1'b0;
      WordSel = 2'd0;
      BusRE   = 1'b0;
      BusWE   = 1'b0;
      BusA    = 32'd0;
    end
  end

endmodule

// File: tb/tb_data_writeback_cache_controller.sv
module tb_data_writeback_cache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, BusReady;
  logic [31:0] A;
  logic        RV, Dirty;
  logic [13:0] RTag;
  logic        Stall, CWE, DirtyIn, UseWD, BusRE, BusWE;
  logic [31:0] CacheA, BusA;
  logic [1:0]  WordSel;

  int checks = 0;
  int errors = 0;

  // Directed drive of the line status, or a cache-array environment model.
  logic        env_en;
  logic        d_rv, d_dirty;
  logic [13:0] d_rtag;
  bit          c_valid [16384];
  bit          c_dirty [16384];
  bit   [13:0] c_tag   [16384];

  assign RV    = env_en ? c_valid[A[17:4]] : d_rv;
  assign Dirty = env_en ? c_dirty[A[17:4]] : d_dirty;
  assign RTag  = env_en ? c_tag[A[17:4]]   : d_rtag;

  always @(posedge clk) begin
    if (env_en && CWE) begin
      c_valid[CacheA[17:4]] <= 1'b1;
      c_tag[CacheA[17:4]]   <= CacheA[31:18];
      c_dirty[CacheA[17:4]] <= DirtyIn;
    end
  end

  always #5 clk = ~clk;

  data_writeback_cache_controller #(.tagbits(14)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .A(A),
    .RV(RV), .Dirty(Dirty), .RTag(RTag), .BusReady(BusReady), .Stall(Stall), .CWE(CWE),
    .DirtyIn(DirtyIn), .UseWD(UseWD), .CacheA(CacheA), .WordSel(WordSel), .BusRE(BusRE),
    .BusWE(BusWE), .BusA(BusA)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; BusReady = 1'b0;
    d_rv = 1'b0; d_dirty = 1'b0; d_rtag = 14'd0; A = 32'd0;
  endtask

  task automatic test_reset();
    env_en = 1'b0;
    idle_inputs();
    reset = 1'b0;
    d_rv = 1'b1; A = 32'h0000_1234; MemWriteM = 1'b1; BusReady = 1'b1;
    #3;
    checks++;
    if ({Stall, CWE, DirtyIn, UseWD, BusRE, BusWE, WordSel} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b exp 00000000",
               {Stall, CWE, DirtyIn, UseWD, BusRE, BusWE, WordSel});
    end
    checks++;
    if (BusA !== 32'd0) begin
      errors++; $display("FAIL reset_busa: got %h exp 00000000", BusA);
    end
    d_rv = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b1;
    #2;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL reset_miss_stall: got %b exp 0", Stall);
    end
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read_hit();
    d_rv = 1'b1; d_rtag = 14'd0; A = 32'h0000_1234; MemReadM = 1'b1;
    @(negedge clk);
    checks++;
    if ({Stall, CWE, BusRE, BusWE} !== 4'b0000) begin
      errors++; $display("FAIL read_hit: got %b exp 0000", {Stall, CWE, BusRE, BusWE});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_write_hit();
    d_rv = 1'b1; d_rtag = 14'd0; A = 32'h0000_1234; MemWriteM = 1'b1;
    @(negedge clk);
    checks++;
    if ({Stall, CWE, UseWD, DirtyIn, BusRE, BusWE} !== 6'b011100) begin
      errors++;
      $display("FAIL write_hit: got %b exp 011100", {Stall, CWE, UseWD, DirtyIn, BusRE, BusWE});
    end
    checks++;
    if (CacheA !== 32'h0000_1234) begin
      errors++; $display("FAIL write_hit_cachea: got %h exp 00001234", CacheA);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_clean_miss();
    d_rv = 1'b0; A = 32'h0000_1230; MemReadM = 1'b1; BusReady = 1'b1;
    @(negedge clk);
    checks++;
    if ({Stall, CWE, BusRE, BusWE} !== 4'b1000) begin
      errors++; $display("FAIL clean_decision: got %b exp 1000", {Stall, CWE, BusRE, BusWE});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({Stall, BusRE, BusWE, CWE, UseWD, DirtyIn} !== 6'b110100 ||
          BusA !== 32'h0000_1230 + 32'(4 * k) || CacheA !== BusA) begin
        errors++;
        $display("FAIL clean_fill_%0d: got flags %b busa %h cachea %h exp 110100 %h", k,
                 {Stall, BusRE, BusWE, CWE, UseWD, DirtyIn}, BusA, CacheA,
                 32'h0000_1230 + 32'(4 * k));
      end
    end
    tick();
    d_rv = 1'b1; d_rtag = 14'd0;
    @(negedge clk);
    checks++;
    if ({Stall, BusRE} !== 2'b00) begin
      errors++; $display("FAIL clean_replay_6th: got %b exp 00", {Stall, BusRE});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_dirty_miss();
    d_rv = 1'b1; d_dirty = 1'b1; d_rtag = 14'h0005; A = 32'h8000_0040;
    MemReadM = 1'b1; BusReady = 1'b1;
    @(negedge clk);
    checks++;
    if ({Stall, BusRE, BusWE} !== 3'b100) begin
      errors++; $display("FAIL dirty_decision: got %b exp 100", {Stall, BusRE, BusWE});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({Stall, BusWE, BusRE, CWE} !== 4'b1100 || BusA !== 32'h0014_0040 + 32'(4 * k) ||
          WordSel !== 2'(k)) begin
        errors++;
        $display("FAIL dirty_wb_%0d: got flags %b busa %h wsel %0d exp 1100 %h %0d", k,
                 {Stall, BusWE, BusRE, CWE}, BusA, WordSel, 32'h0014_0040 + 32'(4 * k), k);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({Stall, BusWE, BusRE, CWE} !== 4'b1011 || BusA !== 32'h8000_0040 + 32'(4 * k)) begin
        errors++;
        $display("FAIL dirty_fill_%0d: got flags %b busa %h exp 1011 %h", k,
                 {Stall, BusWE, BusRE, CWE}, BusA, 32'h8000_0040 + 32'(4 * k));
      end
    end
    tick();
    d_rv = 1'b1; d_dirty = 1'b0; d_rtag = 14'h2000;
    @(negedge clk);
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL dirty_replay: got %b exp 0", Stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    d_rv = 1'b0; A = 32'h0000_1230; MemReadM = 1'b1; BusReady = 1'b1;
    tick();   // FETCH word 0
    tick();   // word 1
    tick();   // word 2
    BusReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({Stall, BusRE, CWE} !== 3'b110 || BusA !== 32'h0000_1238) begin
        errors++;
        $display("FAIL backpressure_%0d: got flags %b busa %h exp 110 00001238", c,
                 {Stall, BusRE, CWE}, BusA);
      end
      tick();
    end
    BusReady = 1'b1;
    @(negedge clk);
    checks++;
    if ({BusRE, CWE} !== 2'b11 || BusA !== 32'h0000_1238) begin
      errors++;
      $display("FAIL backpressure_resume: got flags %b busa %h exp 11 00001238",
               {BusRE, CWE}, BusA);
    end
    tick();   // word 3
    tick();   // back to READY
    d_rv = 1'b1; d_rtag = 14'd0;
    @(negedge clk);
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL backpressure_replay: got %b exp 0", Stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_writeback();
    d_rv = 1'b1; d_dirty = 1'b1; d_rtag = 14'h0005; A = 32'h8000_0040;
    MemReadM = 1'b1; BusReady = 1'b1;
    tick();   // WRITEBACK cnt 0
    tick();   // WRITEBACK cnt 1
    BusReady = 1'b0;
    @(negedge clk);
    checks++;
    if (BusWE !== 1'b1 || WordSel !== 2'd1) begin
      errors++; $display("FAIL midwb_setup: got we %b wsel %0d exp 1 1", BusWE, WordSel);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({BusWE, Stall} !== 2'b00) begin
      errors++; $display("FAIL midwb_async: got %b exp 00", {BusWE, Stall});
    end
    @(posedge clk); #1;
    d_rv = 1'b0; d_dirty = 1'b0; A = 32'h0000_1230; BusReady = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({Stall, BusRE, BusWE} !== 3'b100) begin
      errors++; $display("FAIL midwb_reeval: got %b exp 100", {Stall, BusRE, BusWE});
    end
    tick();
    @(negedge clk);
    checks++;
    if (BusRE !== 1'b1 || BusA !== 32'h0000_1230) begin
      errors++; $display("FAIL midwb_cnt0: got re %b busa %h exp 1 00001230", BusRE, BusA);
    end
    for (int k = 0; k < 4; k++) tick();
    idle_inputs();
    tick();
  endtask

  // Random loads/stores against a line-level reference of the cache contents.
  task automatic test_random();
    bit          m_valid [4];
    bit          m_dirty [4];
    bit   [13:0] m_tag   [4];
    logic [32:0] exp_q [$];
    logic [13:0] t, ix;
    logic [1:0]  w;
    logic        wr, hit, done, bad, both;
    logic [31:0] addr;
    logic [32:0] obs;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 14'd0;
    end
    env_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      t    = 14'($urandom_range(0, 3));
      ix   = 14'($urandom_range(0, 3));
      w    = 2'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      addr = {t, ix, w, 2'b00};
      hit  = m_valid[ix[1:0]] && (m_tag[ix[1:0]] == t);
      exp_q.delete();
      if (!hit) begin
        if (m_valid[ix[1:0]] && m_dirty[ix[1:0]])
          for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, m_tag[ix[1:0]], ix, 2'(k), 2'b00});
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, t, ix, 2'(k), 2'b00});
      end
      A = addr; MemWriteM = wr; MemReadM = ~wr;
      BusReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (Stall !== ~hit) begin
        errors++; $display("FAIL rnd_hit_%0d: got stall %b exp %b addr %h", n, Stall, ~hit, addr);
      end
      done = 1'b0; bad = 1'b0; both = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if ((BusRE && BusWE) || (BusWE && CWE)) both = 1'b1;
        if (!Stall) begin
          done = 1'b1;
          break;
        end
        if (BusReady && (BusRE || BusWE)) begin
          obs = {BusWE, BusA};
          if (exp_q.size() == 0 || obs !== exp_q[0]) bad = 1'b1;
          else void'(exp_q.pop_front());
        end
        tick();
        BusReady = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
      checks++;
      if (!done || bad || both || exp_q.size() != 0) begin
        errors++;
        $display("FAIL rnd_seq_%0d: done %b order_err %b strobe_err %b left %0d exp 1 0 0 0",
                 n, done, bad, both, exp_q.size());
      end
      checks++;
      if ({CWE, UseWD, DirtyIn} !== {wr, wr, wr}) begin
        errors++;
        $display("FAIL rnd_complete_%0d: got %b exp %b", n, {CWE, UseWD, DirtyIn}, {wr, wr, wr});
      end
      tick();
      m_dirty[ix[1:0]] = hit ? (m_dirty[ix[1:0]] | wr) : wr;
      m_valid[ix[1:0]] = 1'b1;
      m_tag[ix[1:0]]   = t;
      MemReadM = 1'b0; MemWriteM = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({c_valid[i], c_dirty[i], c_tag[i]} !== {m_valid[i], m_dirty[i], m_tag[i]}) begin
        errors++;
        $display("FAIL rnd_line_%0d: got v%b d%b t%h exp v%b d%b t%h", i, c_valid[i],
                 c_dirty[i], c_tag[i], m_valid[i], m_dirty[i], m_tag[i]);
      end
    end
    env_en = 1'b0;
  endtask

  initial begin
    env_en = 1'b0;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_backpressure();
    test_reset_mid_writeback();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
